// File: rtl/adder_sequencer.sv
// Multi-cycle WIDTH-bit adder that time-shares an external CHUNK-bit combinational
// Adder slice, rippling the carry between slices least-significant chunk first.
module adder_sequencer #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in_lhs,
  input  logic [WIDTH-1:0] in_rhs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             add_cin,
  output logic [CHUNK-1:0] add_lhs,
  output logic [CHUNK-1:0] add_rhs,
  input  logic [CHUNK-1:0] add_out,
  input  logic             add_cout,
  output logic [7:0]       ops_done
);
  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  // state | meaning
  // IDLE  | waiting for an operand pair, in_ready high
  // RUN   | one Adder slice per cycle, idx selects the chunk
  // DONE  | result presented, held until out_ready
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  lhs_q, lhs_d, rhs_q, rhs_d, sum_q, sum_d;
  logic [WIDTH-1:0]  out_sum_q, out_sum_d;
  logic              carry_q, carry_d, out_cout_q, out_cout_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [7:0]        ops_done_q, ops_done_d;
  logic [CHUNK-1:0]  lhs_chunk, rhs_chunk;

  always_comb begin
    lhs_chunk = '0;
    rhs_chunk = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDXW'(i)) begin
        lhs_chunk = lhs_q[i*CHUNK +: CHUNK];
        rhs_chunk = rhs_q[i*CHUNK +: CHUNK];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lhs_d      = lhs_q;
    rhs_d      = rhs_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    ops_done_d = ops_done_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          lhs_d   = in_lhs;
          rhs_d   = in_rhs;
          carry_d = in_cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDXW'(i)) sum_d[i*CHUNK +: CHUNK] = add_out;
        end
        carry_d = add_cout;
        // Final slice: publish the completed sum into the held output registers.
        if (idx_q == IDXW'(N - 1)) begin
          idx_d      = '0;
          out_sum_d  = sum_d;
          out_cout_d = add_cout;
          state_d    = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          ops_done_d = ops_done_q + 8'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      lhs_q      <= '0;
      rhs_q      <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      ops_done_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      lhs_q      <= lhs_d;
      rhs_q      <= rhs_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign ops_done  = ops_done_q;
  assign add_lhs   = (state_q == RUN) ? lhs_chunk : '0;
  assign add_rhs   = (state_q == RUN) ? rhs_chunk : '0;
  assign add_cin   = (state_q == RUN) ? carry_q : 1'b0;

endmodule

// File: tb/tb_adder_sequencer.sv
// Scoreboard bench for adder_sequencer: directed cases, randomized operands with random
// output backpressure, mid-run reset, and a single-slice (WIDTH=CHUNK) instance.
module tb_adder_sequencer;
  localparam int W = 8;
  localparam int C = 2;
  localparam int N = W / C;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0, in_cin = 1'b0;
  logic [W-1:0] in_lhs = '0, in_rhs = '0;
  logic in_ready, out_valid, out_cout, add_cin, add_cout;
  logic out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic [C-1:0] add_lhs, add_rhs, add_out;
  logic [7:0] ops_done;

  logic u2_in_valid = 1'b0, u2_in_cin = 1'b0, u2_out_ready = 1'b1;
  logic [1:0] u2_in_lhs = '0, u2_in_rhs = '0;
  logic u2_in_ready, u2_out_valid, u2_out_cout, u2_add_cin, u2_add_cout;
  logic [1:0] u2_out_sum, u2_add_lhs, u2_add_rhs, u2_add_out;
  logic [7:0] u2_ops_done;

  int  pass_cnt = 0, tot_cnt = 0, cyc = 0, exp_ops = 0;
  bit  rand_ready = 1'b0, ready_force = 1'b1, prev_valid = 1'b0;

  typedef struct { logic [W-1:0] sum; logic cout; int acc; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational Adder slices owned by each sequencer
  assign {add_cout, add_out}       = {1'b0, add_lhs} + {1'b0, add_rhs} + {2'b00, add_cin};
  assign {u2_add_cout, u2_add_out} = {1'b0, u2_add_lhs} + {1'b0, u2_add_rhs} + {2'b00, u2_add_cin};

  adder_sequencer #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_cin(in_cin),
    .in_lhs(in_lhs), .in_rhs(in_rhs), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .add_cin(add_cin), .add_lhs(add_lhs),
    .add_rhs(add_rhs), .add_out(add_out), .add_cout(add_cout), .ops_done(ops_done));

  adder_sequencer #(.WIDTH(2), .CHUNK(2)) u2 (
    .clk(clk), .reset_n(reset_n), .in_valid(u2_in_valid), .in_ready(u2_in_ready),
    .in_cin(u2_in_cin), .in_lhs(u2_in_lhs), .in_rhs(u2_in_rhs), .out_valid(u2_out_valid),
    .out_ready(u2_out_ready), .out_sum(u2_out_sum), .out_cout(u2_out_cout),
    .add_cin(u2_add_cin), .add_lhs(u2_add_lhs), .add_rhs(u2_add_rhs),
    .add_out(u2_add_out), .add_cout(u2_add_cout), .ops_done(u2_ops_done));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Carry entering chunk j of an unsigned add: everything below bit C*j summed, shifted down.
  function automatic int carry_into(int l, int r, int c, int j);
    int mask = (1 << (C * j)) - 1;
    return ((l & mask) + (r & mask) + c) >> (C * j);
  endfunction

  always begin
    @(posedge clk); #2;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Monitor: compares presented results against the scoreboard head.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
      exp_ops = 0;
    end else begin
      chk("ops_done", ops_done, 32'(exp_ops & 255));
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          if (!prev_valid) chk("latency", 32'(cyc - exp_q[0].acc), N);
          chk("out_sum", out_sum, exp_q[0].sum);
          chk("out_cout", out_cout, exp_q[0].cout);
          chk("in_ready_in_done", in_ready, 0);
          chk("add_idle", {add_cin, add_lhs, add_rhs}, 0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            exp_ops++;
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the edge where out_valid rises.
  task automatic issue(input logic [W-1:0] l, input logic [W-1:0] r, input logic c, output int acc);
    int t = 0;
    bit ok = 0;
    int s;
    exp_t e;
    acc = -1;
    in_valid = 1'b1; in_lhs = l; in_rhs = r; in_cin = c;
    while (!ok && t < 100) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        acc = cyc + 1;
        s = int'(l) + int'(r) + int'(c);
        e.sum = W'(s); e.cout = 1'(s >> W); e.acc = acc;
        exp_q.push_back(e);
      end
      t++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
    else begin
      for (int j = 0; j < N; j++) begin
        @(negedge clk);
        chk("add_lhs", add_lhs, (int'(l) >> (C * j)) % (1 << C));
        chk("add_rhs", add_rhs, (int'(r) >> (C * j)) % (1 << C));
        chk("add_cin", add_cin, carry_into(int'(l), int'(r), int'(c), j));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int a0, a1, t;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", {out_cout, out_sum}, 0);
    chk("rst_add", {add_cin, add_lhs, add_rhs}, 0);
    chk("rst_ops_done", ops_done, 0);
    @(negedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic add and full carry ripple
    issue(8'h01, 8'h03, 1'b1, a0);
    @(posedge clk); #1;
    chk("ops_done_basic", ops_done, 1);
    issue(8'hFF, 8'h01, 1'b0, a0);
    @(posedge clk); #1;

    // Backpressure with new operands offered during DONE
    ready_force = 1'b0;
    issue(8'hA5, 8'h5A, 1'b1, a0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_lhs = W'($urandom); in_rhs = W'($urandom); in_cin = 1'($urandom);
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    ready_force = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    @(posedge clk); #1;

    // Reset during the second RUN cycle
    in_valid = 1'b1; in_lhs = 8'h55; in_rhs = 8'h22; in_cin = 1'b0;
    @(negedge clk);
    chk("mr_in_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("mr_in_ready_rst", in_ready, 1);
    chk("mr_out_valid_rst", out_valid, 0);
    chk("mr_out_rst", {out_cout, out_sum}, 0);
    chk("mr_add_rst", {add_cin, add_lhs, add_rhs}, 0);
    chk("mr_ops_done_rst", ops_done, 0);
    @(negedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    issue(8'h10, 8'h20, 1'b0, a0);
    @(posedge clk); #1;

    // Back-to-back with out_ready held high
    issue(8'h80, 8'h80, 1'b0, a0);
    issue(8'h7F, 8'h01, 1'b0, a1);
    chk("b2b_spacing", 32'(a1 - a0), N + 2);
    @(posedge clk); #1;
    chk("ops_done_b2b", ops_done, 3);

    // Randomized operands and random backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), a0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rand_ready = 1'b0; ready_force = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
    chk("drain", exp_q.size(), 0);

    // Single-slice instance: RUN lasts one cycle
    u2_in_valid = 1'b1; u2_in_lhs = 2'd1; u2_in_rhs = 2'd3; u2_in_cin = 1'b1;
    @(negedge clk);
    chk("n1_in_ready", u2_in_ready, 1);
    @(posedge clk); #1 u2_in_valid = 1'b0;
    @(negedge clk);
    chk("n1_run_valid", u2_out_valid, 0);
    chk("n1_run_add", {u2_add_cin, u2_add_lhs, u2_add_rhs}, {1'b1, 2'd1, 2'd3});
    @(negedge clk);
    chk("n1_out_valid", u2_out_valid, 1);
    chk("n1_out", {u2_out_cout, u2_out_sum}, {1'b1, 2'd1});
    @(negedge clk);
    chk("n1_after_valid", u2_out_valid, 0);
    chk("n1_ops_done", u2_ops_done, 1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, tot_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_sequencer.md
# adder_sequencer

Multi-cycle controller that performs a WIDTH-bit addition by driving a narrow CHUNK-bit combinational `Adder` slice (default 2 bits) over WIDTH/CHUNK cycles. The carry is fed back between slices. It accepts operands on a valid/ready input channel, sequences the slice least-significant chunk first, and presents the full sum and carry-out on a valid/ready output channel. It sits between an operand producer and the shared `Adder` instance, which it owns exclusively.

## Interface
- `WIDTH`, default 8: total operand width; must be a multiple of `CHUNK`.
- `CHUNK`, default 2: width of the external `Adder` slice.
- `N` (localparam) = WIDTH/CHUNK: number of slices.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  sequencer can accept an operand.
- `in_cin`  in  1  carry-in for the whole addition.
- `in_lhs`  in  WIDTH  left operand.
- `in_rhs`  in  WIDTH  right operand.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  WIDTH  sum modulo 2^WIDTH.
- `out_cout`  out  1  carry-out of the MSB chunk.
- `add_cin`  out  1  to the `Adder` cin port.
- `add_lhs`  out  CHUNK  to the `Adder` lhs port.
- `add_rhs`  out  CHUNK  to the `Adder` rhs port.
- `add_out`  in  CHUNK  from the `Adder` out port (combinational).
- `add_cout`  in  1  from the `Adder` cout port (combinational).
- `ops_done`  out  8  count of completed results; wraps 255→0.

## Operation
- Internal state:
  - `lhs_r` and `rhs_r` (WIDTH bits each).
  - `sum_r` (WIDTH bits) and `carry_r` (1 bit).
  - `idx` (clog2(N) bits, minimum 1).
  - FSM with states `IDLE`, `RUN` and `DONE`.
- **IDLE**:
  - `in_ready`=1.
  - On `in_valid`: latch `in_lhs`, `in_rhs`; set `carry_r`←`in_cin`, `idx`←0, `sum_r`←0; go to `RUN`.
- **RUN**:
  - Drive `add_lhs`=`lhs_r[idx*CHUNK +: CHUNK]`, `add_rhs`=`rhs_r[idx*CHUNK +: CHUNK]`, `add_cin`=`carry_r`.
  - Each edge: `sum_r[idx*CHUNK +: CHUNK]`←`add_out`, `carry_r`←`add_cout`, `idx`←`idx`+1.
  - At the edge where `idx`==N-1, go to `DONE`.
  - `in_ready`=0.
- **DONE**:
  - `out_valid`=1; `out_sum`=`sum_r`; `out_cout`=`carry_r`.
  - On `out_ready`: `ops_done`+1; go to `IDLE`.
  - `in_ready`=0.
- Outside `RUN`, `add_lhs`/`add_rhs`/`add_cin` are 0.
- `out_sum` and `out_cout` are registered values. They hold their last result outside `DONE`, but are meaningful only while `out_valid`=1.
- Arithmetic is unsigned; the carry ripples chunk to chunk exactly as a WIDTH-bit adder would.
- `in_valid` while not in `IDLE` is ignored; the operands are not captured.
- `out_ready` while not in `DONE` is ignored.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - State → `IDLE`; `in_ready`=1, `out_valid`=0.
  - `out_sum`=0, `out_cout`=0, `add_*`=0, `ops_done`=0, `idx`=0.
  - Takes effect immediately, not at the next edge.
- Reset mid-`RUN` or mid-`DONE`: the in-flight operation is discarded with no result and no `ops_done` increment. The first accept is possible on the first rising edge with `reset_n`=1.
- Accept at edge T (`in_valid`&&`in_ready`):
  - `RUN` occupies edges T+1..T+N.
  - `out_valid` rises after edge T+N, i.e. result latency N cycles (4 at the defaults).
- Result handshake at edge R (`out_valid`&&`out_ready`):
  - `out_valid` falls and `in_ready` rises after R.
  - The next accept is possible at R+1.
  - Minimum period with `out_ready` held high is N+2 cycles.
- Backpressure: `DONE` holds indefinitely with `out_sum`/`out_cout` stable until `out_ready`.
- `add_*` outputs change only after clock edges. The `Adder` is purely combinational, so `add_out`/`add_cout` are sampled in the same cycle they are driven.
- N=1 (CHUNK=WIDTH): `RUN` lasts exactly one cycle.

## Test plan
- **Basic add**: WIDTH=8, CHUNK=2; accept `in_lhs`=0x01, `in_rhs`=0x03, `in_cin`=1 → `out_valid` exactly 4 cycles after accept; `out_sum`=0x05, `out_cout`=0, `ops_done`=1.
- **Full carry ripple**: `in_lhs`=0xFF, `in_rhs`=0x01, `in_cin`=0 → `out_sum`=0x00, `out_cout`=1. Per-cycle `add_cin` sequence is 0,1,1,1.
- **Backpressure**: hold `out_ready`=0 for 5 cycles after `out_valid` rises; keep `in_valid`=1 with new operands → `out_sum`/`out_cout` stable, `in_ready`=0, new operands not captured. Release → result consumed, `in_ready`=1 next cycle.
- **Reset mid-run**: assert `reset_n`=0 during the 2nd `RUN` cycle → all outputs take their reset values immediately, no `out_valid` pulse, `ops_done`=0. A subsequent 0x10+0x20 → 0x30.
- **Back-to-back**: `out_ready`=1 and `in_valid`=1 continuously with 0x80+0x80 then 0x7F+0x01 → results {0x00, cout 1} then {0x80, cout 0}; accepts 6 cycles apart; `ops_done`=2.
- **Degenerate slice**: WIDTH=CHUNK=2; accept `in_lhs`=1, `in_rhs`=3, `in_cin`=1 → `out_sum`=1, `out_cout`=1, `out_valid` 1 cycle after accept.
